sound_sequencer: RTL and testbench

- Initiator side of the sound player's `sound_code`/`play_sound` interface.
- Game/UI logic posts 3-bit sound events through a valid/ready port. The block queues them in a small FIFO.
- It issues one `play_sound` pulse per event, paced so that no note is cut off by the next. A silent gap separates consecutive notes.
- Sits between the game-control FSM and the player; the outputs connect directly to the player's inputs.

---
 rtl/sound_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_sound_sequencer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// sound_sequencer: queues 3-bit sound events in a small FIFO and issues one
// paced play_sound pulse per event to the sound player
// (ISSUE 1 cycle, PLAY NOTE_CYCLES, GAP GAP_CYCLES).
// Optional build macro SOUND_SEQ_WIN_JINGLE_EN: popping code 4 expands into
// the four-note jingle 3, 2, 1, 4 before the FIFO is popped again.
module sound_sequencer #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned NOTE_CYCLES = 10000000,
   parameter int unsigned GAP_CYCLES  = 1000000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       evt_valid,
   input  logic [2:0] evt_code,
   output logic       evt_ready,
   input  logic       clr,
   output logic [2:0] sound_code,
   output logic       play_sound,
   output logic       busy,
   output logic [7:0] drop_cnt
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned MAXC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
   localparam int unsigned CW   = $clog2(MAXC + 1);

   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] NOTE_LOAD = CW'(NOTE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_PLAY,
      S_GAP
   } state_t;

   // FIFO storage and bookkeeping
   logic [2:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic [AW:0]   count_d;

   // Sequencer state
   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    code_q;
   logic          play_q;
   logic [7:0]    drop_q;

   logic          push;
   logic          pop;
   logic          issue;
   logic          jingle_busy;
   logic [2:0]    head;
   logic [2:0]    issue_code;

   // evt_ready is held low while in reset so the producer sees no room
   // until the block is actually running.
   assign evt_ready = rstn && (count_q != FULL_CNT);

   assign head = mem_q[rd_ptr_q];

   assign push = evt_valid && evt_ready && (evt_code != 3'd0) && !clr;

   // A note is issued from IDLE as soon as the FIFO holds something, or at
   // the last GAP cycle if there is another FIFO entry or jingle note.
   assign issue = !clr &&
                  (((state_q == S_IDLE) && (count_q != '0)) ||
                   ((state_q == S_GAP) && (cnt_q == '0) &&
                    ((count_q != '0) || jingle_busy)));

   // Jingle notes are issued without consuming FIFO entries.
   assign pop = issue && !jingle_busy;

`ifdef SOUND_SEQ_WIN_JINGLE_EN
   logic       jingle_q;
   logic [1:0] jidx_q;

   assign jingle_busy = jingle_q;

   // Pick the next note: a jingle step, the jingle opener for code 4, or the FIFO head
   always_comb begin
      issue_code = head;
      if (jingle_q) begin
         case (jidx_q)
            2'd0:    issue_code = 3'd3;
            2'd1:    issue_code = 3'd2;
            2'd2:    issue_code = 3'd1;
            default: issue_code = 3'd4;
         endcase
      end else if (head == 3'd4) begin
         issue_code = 3'd3;
      end
   end

   // Track jingle progress; jidx_q is the index of the next jingle note to issue
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         jingle_q <= 1'b0;
         jidx_q   <= '0;
      end else if (clr) begin
         jingle_q <= 1'b0;
         jidx_q   <= '0;
      end else if (issue) begin
         if (jingle_q) begin
            jidx_q <= jidx_q + 2'd1;
            if (jidx_q == 2'd3) begin
               jingle_q <= 1'b0;
            end
         end else if (head == 3'd4) begin
            jingle_q <= 1'b1;
            jidx_q   <= 2'd1;
         end
      end
   end
`else
   assign jingle_busy = 1'b0;

   // Every code plays as a single note
   always_comb begin
      issue_code = head;
   end
`endif

   // FIFO occupancy: flush wins, simultaneous push and pop cancel out
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) begin
               wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + 1'b1;
            end
         end
      end
   end

   // FIFO storage write port (contents need no reset)
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= evt_code;
      end
   end

   // Saturating count of events refused because the FIFO was full
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         drop_q <= '0;
      end else if (evt_valid && !evt_ready && (evt_code != 3'd0) && (drop_q != '1)) begin
         drop_q <= drop_q + 8'd1;
      end
   end

   // Note pacing FSM with registered sound_code / play_sound
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         code_q  <= '0;
         play_q  <= 1'b0;
      end else begin
         play_q <= 1'b0;
         if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (issue) begin
                     state_q <= S_ISSUE;
                     code_q  <= issue_code;
                     play_q  <= 1'b1;
                  end
               end
               S_ISSUE: begin
                  state_q <= S_PLAY;
                  cnt_q   <= NOTE_LOAD;
               end
               S_PLAY: begin
                  if (cnt_q == '0) begin
                     state_q <= S_GAP;
                     cnt_q   <= GAP_LOAD;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
               S_GAP: begin
                  if (cnt_q != '0) begin
                     cnt_q <= cnt_q - 1'b1;
                  end else if (issue) begin
                     state_q <= S_ISSUE;
                     code_q  <= issue_code;
                     play_q  <= 1'b1;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign sound_code = code_q;
   assign play_sound = play_q;
   assign busy       = (state_q != S_IDLE) || (count_q != '0);
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer (NOTE_CYCLES=8, GAP_CYCLES=2,
// DEPTH=4, pulse period 11). The reference model keeps the FIFO as a queue
// and issues a note at the first edge at least 11 cycles after the previous
// one. Honours SOUND_SEQ_WIN_JINGLE_EN when defined.
module tb_sound_sequencer;

   localparam int DEPTH = 4;
   localparam int NOTE  = 8;
   localparam int GAP   = 2;
   localparam int P     = 1 + NOTE + GAP;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       evt_valid = 1'b0;
   logic [2:0] evt_code = 3'd0;
   logic       clr = 1'b0;
   logic       evt_ready;
   logic [2:0] sound_code;
   logic       play_sound;
   logic       busy;
   logic [7:0] drop_cnt;

   int checks = 0;
   int errors = 0;

   // reference model state
   int         q[$];
   int         jq[$];
   int         cyc = 0;
   int         last = -1000;
   logic [2:0] m_code = 3'd0;
   logic       m_play = 1'b0;
   int         m_drop = 0;

   logic [13:0] obs;
   assign obs = {play_sound, sound_code, busy, evt_ready, drop_cnt};

   sound_sequencer #(
      .DEPTH      (DEPTH),
      .NOTE_CYCLES(NOTE),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .evt_valid (evt_valid),
      .evt_code  (evt_code),
      .evt_ready (evt_ready),
      .clr       (clr),
      .sound_code(sound_code),
      .play_sound(play_sound),
      .busy      (busy),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   function automatic void model_reset();
      q.delete();
      jq.delete();
      last   = -1000;
      m_code = 3'd0;
      m_play = 1'b0;
      m_drop = 0;
   endfunction

   // One clock edge of the reference model, using the inputs as driven now.
   function automatic void model_edge();
      bit ready;
      bit do_issue;
      bit do_push;
      int c;
      cyc++;
      ready    = q.size() < DEPTH;
      do_issue = !clr && (cyc >= last + P) && ((jq.size() > 0) || (q.size() > 0));
      do_push  = evt_valid && ready && (evt_code != 3'd0) && !clr;
      if (evt_valid && !ready && (evt_code != 3'd0) && (m_drop < 255)) m_drop++;
      m_play = 1'b0;
      if (clr) begin
         q.delete();
         jq.delete();
         last = -1000;
      end else if (do_issue) begin
         if (jq.size() > 0) begin
            c = jq.pop_front();
         end else begin
            c = q.pop_front();
`ifdef SOUND_SEQ_WIN_JINGLE_EN
            if (c == 4) begin
               jq = '{2, 1, 4};
               c  = 3;
            end
`endif
         end
         m_code = 3'(c);
         m_play = 1'b1;
         last   = cyc;
      end
      if (do_push) q.push_back(int'(evt_code));
   endfunction

   function automatic logic [13:0] exp_vec();
      logic mb;
      mb = (q.size() != 0) || (jq.size() != 0) || (cyc < last + P);
      return {m_play, m_code, mb, (q.size() < DEPTH) ? 1'b1 : 1'b0, 8'(m_drop)};
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] c);
      evt_valid = v;
      evt_code  = c;
   endtask

   task automatic test_reset();
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (obs !== 14'h0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=%h", obs, 14'h0);
      end
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      #1;
      checks++;
      if (evt_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got=rdy%b busy%b exp=rdy1 busy0", evt_ready, busy);
      end
   endtask

   task automatic test_single();
      drive(1'b1, 3'd2);
      step();
      drive(1'b0, 3'd0);
      checks++;
      if (obs !== exp_vec()) begin
         errors++;
         $display("FAIL single_accept cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      step();
      checks++;
      if (play_sound !== 1'b1 || sound_code !== 3'd2) begin
         errors++;
         $display("FAIL single_latency got=play%b code%0d exp=play1 code2", play_sound, sound_code);
      end
      for (int i = 1; i <= 12; i++) begin
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
         if (i == 10 || i == 11) begin
            checks++;
            if (busy !== (i == 10)) begin
               errors++;
               $display("FAIL single_busy_fall i=%0d got=%b exp=%b", i, busy, (i == 10));
            end
         end
      end
      checks++;
      if (drop_cnt !== 8'd0 || sound_code !== 3'd2) begin
         errors++;
         $display("FAIL single_hold got=drop%0d code%0d exp=drop0 code2", drop_cnt, sound_code);
      end
   endtask

   task automatic test_back_to_back();
      int pt[$];
      int pc[$];
      int exp_c[3] = '{1, 3, 5};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 3'(exp_c[i]));
         step();
         if (play_sound) begin pt.push_back(cyc); pc.push_back(int'(sound_code)); end
      end
      drive(1'b0, 3'd0);
      for (int i = 0; i < 60; i++) begin
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL b2b_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
         if (play_sound) begin pt.push_back(cyc); pc.push_back(int'(sound_code)); end
      end
      checks++;
      if (pt.size() != 3) begin
         errors++;
         $display("FAIL b2b_count got=%0d exp=3", pt.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (pc[i] != exp_c[i]) begin
               errors++;
               $display("FAIL b2b_code i=%0d got=%0d exp=%0d", i, pc[i], exp_c[i]);
            end
         end
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (pt[i] - pt[i-1] != P) begin
               errors++;
               $display("FAIL b2b_spacing i=%0d got=%0d exp=%0d", i, pt[i] - pt[i-1], P);
            end
         end
      end
   endtask

   task automatic test_zero_code();
      int d0;
      d0 = int'(drop_cnt);
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 3'd0);
         step();
         checks++;
         if (play_sound !== 1'b0 || busy !== 1'b0 || int'(drop_cnt) != d0 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL zero_code cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
      end
      drive(1'b0, 3'd0);
   endtask

   task automatic test_overflow();
      int pc[$];
      int codes[6] = '{1, 2, 3, 4, 5, 1};
`ifdef SOUND_SEQ_WIN_JINGLE_EN
      int exp_c[5] = '{1, 2, 3, 3, 2};
`else
      int exp_c[5] = '{1, 2, 3, 4, 5};
`endif
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 3'(codes[i]));
         if (i == 5) begin
            checks++;
            if (evt_ready !== 1'b0) begin
               errors++;
               $display("FAIL ovf_ready got=%b exp=0", evt_ready);
            end
         end
         step();
         if (play_sound) pc.push_back(int'(sound_code));
      end
      drive(1'b0, 3'd0);
      checks++;
      if (drop_cnt !== 8'd1) begin
         errors++;
         $display("FAIL ovf_drop1 got=%0d exp=1", drop_cnt);
      end
      for (int i = 0; i < 50; i++) begin
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL ovf_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
         if (play_sound) pc.push_back(int'(sound_code));
      end
      checks++;
      if (pc.size() != 5) begin
         errors++;
         $display("FAIL ovf_pulses got=%0d exp=5", pc.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (pc[i] != exp_c[i]) begin
               errors++;
               $display("FAIL ovf_code i=%0d got=%0d exp=%0d", i, pc[i], exp_c[i]);
            end
         end
      end
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 3'd5);
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL ovf_sat_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
      end
      drive(1'b0, 3'd0);
      checks++;
      if (drop_cnt !== 8'd255) begin
         errors++;
         $display("FAIL ovf_saturate got=%0d exp=255", drop_cnt);
      end
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic test_clr_reset();
      int ppls;
      drive(1'b1, 3'd1); step();
      drive(1'b1, 3'd2); step();
      drive(1'b1, 3'd3); step();
      drive(1'b0, 3'd0);
      repeat (4) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      checks++;
      if (busy !== 1'b0 || evt_ready !== 1'b1) begin
         errors++;
         $display("FAIL clr_flush got=busy%b rdy%b exp=busy0 rdy1", busy, evt_ready);
      end
      ppls = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (play_sound) ppls++;
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL clr_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
      end
      checks++;
      if (ppls != 0) begin
         errors++;
         $display("FAIL clr_no_pulse got=%0d exp=0", ppls);
      end
      // one event, then reset during its GAP
      drive(1'b1, 3'd5); step();
      drive(1'b0, 3'd0);
      repeat (10) step();
      rstn = 1'b0;
      #1;
      checks++;
      if (obs !== 14'h0) begin
         errors++;
         $display("FAIL reset_mid_gap got=%h exp=%h", obs, 14'h0);
      end
      model_reset();
      @(negedge clk) rstn = 1'b1;
      #1;
   endtask

`ifdef SOUND_SEQ_WIN_JINGLE_EN
   task automatic test_jingle();
      int pt[$];
      int pc[$];
      int exp_c[5] = '{3, 2, 1, 4, 5};
      drive(1'b1, 3'd4); step();
      drive(1'b1, 3'd5); step();
      if (play_sound) begin pt.push_back(cyc); pc.push_back(int'(sound_code)); end
      drive(1'b0, 3'd0);
      for (int i = 0; i < 70; i++) begin
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL jingle_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
         if (play_sound) begin pt.push_back(cyc); pc.push_back(int'(sound_code)); end
      end
      checks++;
      if (pt.size() != 5) begin
         errors++;
         $display("FAIL jingle_count got=%0d exp=5", pt.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (pc[i] != exp_c[i] || (i > 0 && pt[i] - pt[i-1] != P)) begin
               errors++;
               $display("FAIL jingle_note i=%0d got=code%0d exp=code%0d spacing %0d", i, pc[i], exp_c[i], P);
            end
         end
      end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, 3'($urandom_range(0, 5)));
         clr = ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0;
         step();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
         end
      end
      drive(1'b0, 3'd0);
      clr = 1'b0;
      for (int i = 0; i < 80 && busy; i++) step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL random_drain got=busy%b exp=busy0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_zero_code();
      test_overflow();
      test_clr_reset();
`ifdef SOUND_SEQ_WIN_JINGLE_EN
      test_jingle();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
